// File: rtl/uart_tx_cfg.sv
// Per-frame configurable UART transmitter (5..DBITS_MAX data, N/E/O parity, 1/1.5/2 stop), LSB first, tx registered.
// tx falls one clk after a word is accepted into an idle block; din_ready stays low while the one-word hold register is full.
module uart_tx_cfg #(
   parameter int DBITS_MAX = 9,
   parameter int OVS       = 16
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 s_tick,
   input  logic [DBITS_MAX-1:0] din,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic [3:0]           cfg_dbits,
   input  logic [1:0]           cfg_parity,
   input  logic [1:0]           cfg_stop,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int              CW       = $clog2(2*OVS);
   localparam logic [3:0]      DMAX     = 4'(DBITS_MAX);
   localparam logic [CW-1:0]   BIT_TERM = CW'(OVS-1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_nx;
   logic [DBITS_MAX-1:0] hold, shift, shift_nx;
   logic                 hold_valid, hold_valid_nx;
   logic [CW-1:0]        s_cnt, s_term, stop_term_cfg, stop_term_l;
   logic [3:0]           dbits_cfg, dbits_l, bit_cnt;
   logic                 par_en_l, par_odd_l, par_acc, par_nx;
   logic                 accept, load, bit_end, last_data, tx_d;

   // Frame format as it would be latched at the next frame load
   always_comb begin
      dbits_cfg = cfg_dbits;
      if (cfg_dbits < 4'd5)
         dbits_cfg = 4'd5;
      else if (cfg_dbits > DMAX)
         dbits_cfg = DMAX;
      case (cfg_stop)
         2'b00:   stop_term_cfg = CW'(OVS-1);
         2'b01:   stop_term_cfg = CW'(3*OVS/2-1);
         default: stop_term_cfg = CW'(2*OVS-1);
      endcase
   end

   assign s_term        = (state == STOP) ? stop_term_l : BIT_TERM;
   assign bit_end       = s_tick && (s_cnt == s_term) && (state != IDLE);
   assign last_data     = (bit_cnt == dbits_l - 4'd1);
   assign load          = hold_valid && ((state == IDLE) || ((state == STOP) && bit_end));
   assign accept        = din_valid && din_ready;
   assign hold_valid_nx = accept ? 1'b1 : (load ? 1'b0 : hold_valid);
   assign busy          = (state != IDLE) || hold_valid;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load) state_nx = START;
         START:   if (bit_end) state_nx = DATA;
         DATA:    if (bit_end && last_data) state_nx = par_en_l ? PARITY : STOP;
         PARITY:  if (bit_end) state_nx = STOP;
         STOP:    if (bit_end) state_nx = load ? START : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // tx is registered from the next-cycle view so it changes on the same edge as the state
   always_comb begin
      shift_nx = shift;
      par_nx   = par_acc;
      if (load) begin
         shift_nx = hold;
         par_nx   = 1'b0;
      end else if ((state == DATA) && bit_end) begin
         shift_nx = shift >> 1;
         par_nx   = par_acc ^ shift[0];
      end
      case (state_nx)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_nx[0];
         PARITY:  tx_d = par_nx ^ par_odd_l;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         hold        <= '0;
         hold_valid  <= 1'b0;
         din_ready   <= 1'b1;
         shift       <= '0;
         par_acc     <= 1'b0;
         s_cnt       <= '0;
         bit_cnt     <= '0;
         dbits_l     <= 4'd5;
         par_en_l    <= 1'b0;
         par_odd_l   <= 1'b0;
         stop_term_l <= BIT_TERM;
         tx          <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         if (accept)
            hold <= din;
         hold_valid <= hold_valid_nx;
         din_ready  <= !hold_valid_nx;
         shift      <= shift_nx;
         par_acc    <= par_nx;
         tx         <= tx_d;
         frame_done <= (state == STOP) && bit_end;
         if (load || bit_end)
            s_cnt <= '0;
         else if ((state != IDLE) && s_tick)
            s_cnt <= s_cnt + 1'b1;
         if (load)
            bit_cnt <= '0;
         else if ((state == DATA) && bit_end)
            bit_cnt <= bit_cnt + 4'd1;
         if (load) begin
            dbits_l     <= dbits_cfg;
            par_en_l    <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd_l   <= (cfg_parity == 2'b10);
            stop_term_l <= stop_term_cfg;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: words are driven with their expected frames queued, then frames captured from tx and compared.
module tb_uart_tx_cfg;
   localparam int DBITS_MAX = 9;
   localparam int OVS       = 16;

   logic                 clk = 1'b0;
   logic                 areset = 1'b0;
   logic                 s_tick;
   logic [DBITS_MAX-1:0] din = '0;
   logic                 din_valid = 1'b0;
   logic [3:0]           cfg_dbits = 4'd8;
   logic [1:0]           cfg_parity = 2'b00;
   logic [1:0]           cfg_stop = 2'b00;
   logic                 din_ready, tx, busy, frame_done;

   typedef struct packed {
      logic [11:0] bits;
      int          nbits;
      int          stop_t;
   } exp_t;

   exp_t exp_q[$];
   logic wave[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tick_div = 1;
   int   tcnt = 0;

   uart_tx_cfg #(.DBITS_MAX(DBITS_MAX), .OVS(OVS)) dut (
      .clk(clk), .areset(areset), .s_tick(s_tick),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
      .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tick_div <= 1) s_tick = 1'b1;
      else begin
         tcnt = (tcnt + 1) % tick_div;
         s_tick = (tcnt == 0);
      end
   end

   function automatic exp_t model(input logic [DBITS_MAX-1:0] d, input logic [3:0] db,
                                  input logic [1:0] par, input logic [1:0] st);
      exp_t e;
      int   dbi, n;
      logic p;
      dbi = int'(db);
      n = (dbi < 5) ? 5 : ((dbi > DBITS_MAX) ? DBITS_MAX : dbi);
      e = '0;
      p = 1'b0;
      for (int i = 0; i < n; i++) begin
         e.bits[1+i] = d[i];
         p = p ^ d[i];
      end
      e.nbits = 1 + n;
      if (par == 2'b01 || par == 2'b10) begin
         e.bits[1+n] = (par == 2'b10) ? ~p : p;
         e.nbits = e.nbits + 1;
      end
      e.stop_t = (st == 2'b00) ? OVS : ((st == 2'b01) ? OVS*3/2 : 2*OVS);
      return e;
   endfunction

   task automatic send_word(input logic [DBITS_MAX-1:0] d, input bit push);
      int w = 0;
      @(negedge clk);
      din = d;
      din_valid = 1'b1;
      if (push) exp_q.push_back(model(d, cfg_dbits, cfg_parity, cfg_stop));
      while (din_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   // Call at a negedge: waits for tx low, samples every clk until the next frame_done pulse.
   task automatic capture(input int nb, input int div, output int waitc, output int len,
                          output logic [11:0] got, output int stop_bad, output int rdy_hi, output bit to);
      int p = OVS * div;
      waitc = 0; len = 0; got = '0; stop_bad = 0; rdy_hi = 0; to = 1'b0;
      wave.delete();
      while (tx !== 1'b0 && waitc < 2000) begin @(negedge clk); waitc++; end
      if (tx !== 1'b0) begin to = 1'b1; return; end
      do begin
         wave.push_back(tx);
         if (din_ready === 1'b1) rdy_hi++;
         @(negedge clk);
         len++;
      end while (frame_done !== 1'b1 && len < 3000);
      if (frame_done !== 1'b1) to = 1'b1;
      for (int i = 0; i < nb; i++) if (i*p + p/2 < len) got[i] = wave[i*p + p/2];
      for (int i = nb*p; i < len; i++) if (wave[i] !== 1'b1) stop_bad++;
   endtask

   task automatic test_reset();
      areset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
      n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
      areset = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_ticks tx=%b busy=%b exp 1/0", tx, busy); end
   endtask

   task automatic test_8n1();
      exp_t e; int w, l, sb, rh; logic [11:0] g; bit to;
      cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
      send_word(9'h0A5, 1'b1);
      n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL 8n1_rdy_held got=%b exp=0", din_ready); end
      n_cmp++; if (tx !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL 8n1_pre_start tx=%b busy=%b exp 1/1", tx, busy); end
      @(negedge clk);
      n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL 8n1_tx_fall got=%b exp=0", tx); end
      n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL 8n1_rdy_rise got=%b exp=1", din_ready); end
      e = exp_q.pop_front();
      capture(e.nbits, 1, w, l, g, sb, rh, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL 8n1_timeout got=%b exp=0", to); end
      n_cmp++; if (g !== e.bits) begin n_bad++; $display("FAIL 8n1_bits got=%h exp=%h", g, e.bits); end
      n_cmp++; if (l != 160) begin n_bad++; $display("FAIL 8n1_len got=%0d exp=160", l); end
      n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL 8n1_stop low_clks=%0d exp=0", sb); end
   endtask

   task automatic test_7e2();
      exp_t e; int w, l, sb, rh; logic [11:0] g; bit to;
      cfg_dbits = 4'd7; cfg_parity = 2'b01; cfg_stop = 2'b10;
      send_word(9'h041, 1'b1);
      e = exp_q.pop_front();
      capture(e.nbits, 1, w, l, g, sb, rh, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL 7e2_timeout got=%b exp=0", to); end
      n_cmp++; if (g !== e.bits) begin n_bad++; $display("FAIL 7e2_bits got=%h exp=%h", g, e.bits); end
      n_cmp++; if (g[8] !== 1'b0) begin n_bad++; $display("FAIL 7e2_parity got=%b exp=0", g[8]); end
      n_cmp++; if (l != 176) begin n_bad++; $display("FAIL 7e2_len got=%0d exp=176", l); end
      n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL 7e2_stop low_clks=%0d exp=0", sb); end
   endtask

   task automatic test_9o15();
      exp_t e; int w, l, sb, rh; logic [11:0] g; bit to;
      cfg_dbits = 4'd9; cfg_parity = 2'b10; cfg_stop = 2'b01;
      send_word(9'h1FF, 1'b1);
      e = exp_q.pop_front();
      capture(e.nbits, 1, w, l, g, sb, rh, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL 9o15_timeout got=%b exp=0", to); end
      n_cmp++; if (g !== e.bits) begin n_bad++; $display("FAIL 9o15_bits got=%h exp=%h", g, e.bits); end
      n_cmp++; if (g[10] !== 1'b0) begin n_bad++; $display("FAIL 9o15_parity got=%b exp=0", g[10]); end
      n_cmp++; if (l != 200) begin n_bad++; $display("FAIL 9o15_len got=%0d exp=200", l); end
      n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL 9o15_stop low_clks=%0d exp=0", sb); end
      n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_bad++; $display("FAIL 9o15_idle busy=%b tx=%b exp 0/1", busy, tx); end
   endtask

   task automatic test_back_to_back();
      exp_t e1, e2; int w1, l1, sb1, rh1, w2, l2, sb2, rh2, acc2; logic [11:0] g1, g2; bit to1, to2;
      cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
      acc2 = -1;
      @(negedge clk);
      din = 9'h012; din_valid = 1'b1;
      exp_q.push_back(model(9'h012, cfg_dbits, cfg_parity, cfg_stop));
      exp_q.push_back(model(9'h034, cfg_dbits, cfg_parity, cfg_stop));
      fork
         begin
            int w = 0;
            while (din_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
            @(negedge clk);
            din = 9'h034;
            w = 0;
            while (din_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
            @(negedge clk);
            din_valid = 1'b0;
            acc2 = w;
         end
         begin
            e1 = exp_q.pop_front();
            capture(e1.nbits, 1, w1, l1, g1, sb1, rh1, to1);
            e2 = exp_q.pop_front();
            capture(e2.nbits, 1, w2, l2, g2, sb2, rh2, to2);
         end
      join
      n_cmp++; if (to1 !== 1'b0 || to2 !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout got=%b%b exp=00", to1, to2); end
      n_cmp++; if (g1 !== e1.bits) begin n_bad++; $display("FAIL b2b_bits1 got=%h exp=%h", g1, e1.bits); end
      n_cmp++; if (g2 !== e2.bits) begin n_bad++; $display("FAIL b2b_bits2 got=%h exp=%h", g2, e2.bits); end
      n_cmp++; if (l1 != 160 || l2 != 160) begin n_bad++; $display("FAIL b2b_len got=%0d/%0d exp=160/160", l1, l2); end
      n_cmp++; if (w2 != 0) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=0", w2); end
      n_cmp++; if (rh1 != 1) begin n_bad++; $display("FAIL b2b_rdy_in_frame1 got=%0d exp=1", rh1); end
      n_cmp++; if (acc2 != 1) begin n_bad++; $display("FAIL b2b_accept2_wait got=%0d exp=1", acc2); end
      n_cmp++; if (sb1 != 0 || sb2 != 0) begin n_bad++; $display("FAIL b2b_stop low_clks=%0d/%0d exp=0", sb1, sb2); end
   endtask

   task automatic test_reset_mid();
      exp_t e; int w, l, sb, rh, fd; logic [11:0] g; bit to;
      cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
      send_word(9'h0F0, 1'b0);
      @(negedge clk);
      repeat (4*OVS + OVS/2) @(negedge clk);
      areset = 1'b0;
      #1;
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_rdy got=%b exp=1", din_ready); end
      fd = 0;
      repeat (4) begin @(negedge clk); if (frame_done === 1'b1) fd++; end
      areset = 1'b1;
      repeat (40) begin @(negedge clk); if (frame_done === 1'b1 || tx !== 1'b1) fd++; end
      n_cmp++; if (fd != 0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d exp=0", fd); end
      send_word(9'h055, 1'b1);
      @(negedge clk);
      cfg_dbits = 4'd5; cfg_parity = 2'b10; cfg_stop = 2'b01;
      e = exp_q.pop_front();
      capture(e.nbits, 1, w, l, g, sb, rh, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout got=%b exp=0", to); end
      n_cmp++; if (g !== e.bits) begin n_bad++; $display("FAIL rstmid_bits got=%h exp=%h", g, e.bits); end
      n_cmp++; if (l != 160) begin n_bad++; $display("FAIL rstmid_len got=%0d exp=160", l); end
   endtask

   task automatic test_slow_tick();
      exp_t e; int w, l, sb, rh, r, f; logic [11:0] g; bit to;
      tick_div = 4;
      cfg_dbits = 4'd2; cfg_parity = 2'b00; cfg_stop = 2'b00;
      send_word(9'h035, 1'b1);
      e = exp_q.pop_front();
      capture(e.nbits, 4, w, l, g, sb, rh, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL slow_timeout got=%b exp=0", to); end
      n_cmp++; if (g !== e.bits) begin n_bad++; $display("FAIL slow_bits got=%h exp=%h", g, e.bits); end
      n_cmp++; if (l < 445 || l > 448) begin n_bad++; $display("FAIL slow_len got=%0d exp=445..448", l); end
      r = -1; f = -1;
      foreach (wave[i]) begin
         if (r < 0 && wave[i] === 1'b1) r = i;
         else if (r >= 0 && f < 0 && wave[i] === 1'b0) f = i;
      end
      n_cmp++; if (f - r != 64) begin n_bad++; $display("FAIL slow_bit_period got=%0d exp=64", f - r); end
      n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL slow_stop low_clks=%0d exp=0", sb); end
      tick_div = 1;
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_7e2();
      test_9o15();
      test_back_to_back();
      test_reset_mid();
      test_slow_tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
